// File: rtl/bus_rr_arbiter_if.sv
// Bus-arbiter handshake bundle: source requests/data in,
// registered broadcast bus and grant status out.
interface bus_rr_arbiter_if #(
  parameter int p_data_width = 16,
  parameter int p_num_src    = 7,
  parameter int p_id_width   = 4
);

  logic [p_num_src-1:0]              i_w_req;
  logic [p_num_src-1:0]              i_w_lock;
  logic [p_num_src*p_data_width-1:0] i_w_data;
  logic [p_data_width-1:0]           o_w_bus;
  logic                              o_w_bus_valid;
  logic [p_num_src-1:0]              o_w_grant;
  logic [p_id_width-1:0]             o_w_src_id;
  logic [15:0]                       o_w_contention_cnt;

  modport master (
    output i_w_req,
    output i_w_lock,
    output i_w_data,
    input  o_w_bus,
    input  o_w_bus_valid,
    input  o_w_grant,
    input  o_w_src_id,
    input  o_w_contention_cnt
  );

  modport slave (
    input  i_w_req,
    input  i_w_lock,
    input  i_w_data,
    output o_w_bus,
    output o_w_bus_valid,
    output o_w_grant,
    output o_w_src_id,
    output o_w_contention_cnt
  );

endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbitrated broadcast bus with per-source lock.
// Optional saturating contention counter: BUS_CONTENTION_CNT_EN.
module bus_rr_arbiter #(
  parameter int p_data_width = 16,
  parameter int p_num_src    = 7,
  parameter int p_id_width   = 4
) (
  input  logic           i_w_clk,
  input  logic           i_w_reset,
  bus_rr_arbiter_if.slave bus
);

  localparam int DW = p_data_width;
  localparam int NS = p_num_src;
  localparam int IW = p_id_width;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   last_d;
  logic [IW-1:0]   id_q;
  logic [IW-1:0]   id_d;
  logic [NS-1:0]   grant_q;
  logic [NS-1:0]   grant_d;
  logic [DW-1:0]   bus_q;
  logic [DW-1:0]   bus_d;

  logic [NS-1:0]   req;
  logic [NS-1:0]   lock;
  logic            hold;
  logic            rr_found;
  logic [IW-1:0]   rr_idx;
  logic [IW-1:0]   win;
  int              cand;

  assign req  = bus.i_w_req;
  assign lock = bus.i_w_lock;

  function automatic logic bit_at(
    input logic [NS-1:0] v,
    input int            idx
  );
    bit_at = 1'b0;
    for (int j = 0; j < NS; j++) begin
      if (j == idx) bit_at = v[j];
    end
  endfunction

  function automatic logic [DW-1:0] word_at(
    input logic [NS*DW-1:0] v,
    input logic [IW-1:0]    idx
  );
    word_at = '0;
    for (int j = 0; j < NS; j++) begin
      if (idx == IW'(j)) word_at = v[j*DW +: DW];
    end
  endfunction

  // holder keeps the bus only while it both requests and locks
  always_comb begin
    hold = (state_q == ST_BUSY)
         && bit_at(req, int'(id_q))
         && bit_at(lock, int'(id_q));
  end

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int i = 1; i <= NS; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NS) cand = cand - NS;
      if (!rr_found && bit_at(req, cand)) begin
        rr_found = 1'b1;
        rr_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    last_d  = last_q;
    win     = '0;
    id_d    = '0;
    grant_d = '0;
    bus_d   = '0;
    if (hold) begin
      state_d = ST_BUSY;
      win     = id_q;
    end else if (rr_found) begin
      state_d = ST_BUSY;
      win     = rr_idx;
      last_d  = rr_idx;
    end
    if (state_d == ST_BUSY) begin
      id_d    = win;
      grant_d = {{(NS-1){1'b0}}, 1'b1} << win;
      bus_d   = word_at(bus.i_w_data, win);
    end
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NS - 1);
      id_q    <= '0;
      grant_q <= '0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      bus_q   <= bus_d;
    end
  end

  assign bus.o_w_bus       = bus_q;
  assign bus.o_w_bus_valid = (state_q == ST_BUSY);
  assign bus.o_w_grant     = grant_q;
  assign bus.o_w_src_id    = id_q;

`ifdef BUS_CONTENTION_CNT_EN
  logic [15:0] cnt_q;
  logic        contended;

  // counts lock-blocked cycles too: any edge with 2+ requesters
  assign contended = ($countones(req) >= 2);

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      cnt_q <= '0;
    end else if (contended && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.o_w_contention_cnt = cnt_q;
`else
  assign bus.o_w_contention_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed-vector bench for bus_rr_arbiter.
// Covers reset, idle, round robin, lock, release and counter.
module tb_bus_rr_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [15:0] dv [7];

  bus_rr_arbiter_if #(
    .p_data_width(16),
    .p_num_src(7),
    .p_id_width(4)
  ) bif ();

  bus_rr_arbiter #(
    .p_data_width(16),
    .p_num_src(7),
    .p_id_width(4)
  ) dut (
    .i_w_clk(clk),
    .i_w_reset(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic exp_out(
    input string       tag,
    input logic [6:0]  g,
    input logic [3:0]  id,
    input logic [15:0] b,
    input logic        v
  );
    chk({tag, ".grant"}, 32'(bif.o_w_grant), 32'(g));
    chk({tag, ".id"}, 32'(bif.o_w_src_id), 32'(id));
    chk({tag, ".bus"}, 32'(bif.o_w_bus), 32'(b));
    chk({tag, ".valid"}, 32'(bif.o_w_bus_valid), 32'(v));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int k = 0; k < 7; k++) bif.i_w_data[k*16 +: 16] = dv[k];
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int k = 0; k < 7; k++) dv[k] = 16'hC000 + 16'(k);
    pack();
    bif.i_w_req  = '0;
    bif.i_w_lock = '0;
    rst = 1'b1;
    tick();
    tick();
    exp_out("rst", 7'b0, 4'd0, 16'h0, 1'b0);
    chk("rst.cnt", 32'(bif.o_w_contention_cnt), 32'd0);
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      tick();
      exp_out("idle", 7'b0, 4'd0, 16'h0, 1'b0);
    end

    dv[2] = 16'hA5A5;
    pack();
    bif.i_w_req = 7'b0000100;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp_out("single", 7'b0000100, 4'd2, 16'hA5A5, 1'b1);
    end

    rst = 1'b1;
    #1;
    exp_out("midrst", 7'b0, 4'd0, 16'h0, 1'b0);
    tick();
    rst = 1'b0;
    dv[2] = 16'hC002;
    pack();

    bif.i_w_req = 7'b1000101;
    tick();
    exp_out("rr0", 7'b0000001, 4'd0, 16'hC000, 1'b1);
    tick();
    exp_out("rr1", 7'b0000100, 4'd2, 16'hC002, 1'b1);
    tick();
    exp_out("rr2", 7'b1000000, 4'd6, 16'hC006, 1'b1);
    tick();
    exp_out("rr3", 7'b0000001, 4'd0, 16'hC000, 1'b1);
    bif.i_w_req = '0;
    tick();
    exp_out("rridle", 7'b0, 4'd0, 16'h0, 1'b0);

    rst_pulse();
    bif.i_w_req  = 7'b0001010;
    bif.i_w_lock = 7'b0000010;
    tick();
    exp_out("lock0", 7'b0000010, 4'd1, 16'hC001, 1'b1);
    dv[1] = 16'h1111;
    pack();
    tick();
    exp_out("lock1", 7'b0000010, 4'd1, 16'h1111, 1'b1);
    tick();
    exp_out("lock2", 7'b0000010, 4'd1, 16'h1111, 1'b1);
    bif.i_w_lock = '0;
    tick();
    exp_out("unlock", 7'b0001000, 4'd3, 16'hC003, 1'b1);
    dv[1] = 16'hC001;
    pack();

    rst_pulse();
    bif.i_w_req  = 7'b0010010;
    bif.i_w_lock = 7'b0000010;
    tick();
    exp_out("rel0", 7'b0000010, 4'd1, 16'hC001, 1'b1);
    bif.i_w_req = 7'b0010000;
    tick();
    exp_out("rel1", 7'b0010000, 4'd4, 16'hC004, 1'b1);
    bif.i_w_req  = '0;
    bif.i_w_lock = '0;
    tick();
    exp_out("relidle", 7'b0, 4'd0, 16'h0, 1'b0);

    rst_pulse();
    bif.i_w_req = 7'b0000011;
    repeat (10) tick();
`ifdef BUS_CONTENTION_CNT_EN
    chk("cnt10", 32'(bif.o_w_contention_cnt), 32'd10);
    repeat (65540) tick();
    chk("cntsat", 32'(bif.o_w_contention_cnt), 32'hFFFF);
    repeat (3) tick();
    chk("cnthold", 32'(bif.o_w_contention_cnt), 32'hFFFF);
`else
    chk("cntoff", 32'(bif.o_w_contention_cnt), 32'd0);
`endif
    bif.i_w_req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Parametrised successor to the wired-OR datapath bus.
- N sources request the bus. A round-robin arbiter grants one source per cycle. The winner's data is registered onto a single broadcast bus.
- All destinations (RAM, IO, regs, CP, IND, AM, AIE, T1, T2, RI) read o_w_bus when o_w_bus_valid is high.
- Replaces OR-merging with arbitration, so two sources can no longer corrupt each other. Adds bus locking for multi-cycle transfers.

Parameters:
- p_data_width, 16, width of each source data word and of the bus.
- p_num_src, 7, number of bus sources (ALU, RAM, IO, REGS, CP, IND, OFFSET by default); legal range 2..16.
- p_id_width, 4, width of the source index output; must satisfy 2^p_id_width >= p_num_src.

Ports:
- i_w_clk  input  1  clock; all state updates on the rising edge.
- i_w_reset  input  1  asynchronous, active-high reset.
- i_w_req  input  p_num_src  per-source bus request; bit k belongs to source k.
- i_w_lock  input  p_num_src  per-source lock; keeps an existing grant while it is held.
- i_w_data  input  p_num_src*p_data_width  flattened source data; source k occupies bits [k*p_data_width +: p_data_width].
- o_w_bus  output  p_data_width  registered bus value.
- o_w_bus_valid  output  1  high when o_w_bus holds data from a granted source this cycle.
- o_w_grant  output  p_num_src  registered one-hot grant; all zero when idle.
- o_w_src_id  output  p_id_width  binary index of the granted source; 0 when idle.
- o_w_contention_cnt  output  16  contention counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer):
  - o_w_bus=0, o_w_bus_valid=0, o_w_grant=0, o_w_src_id=0, o_w_contention_cnt=0.
  - Round-robin pointer l_r_last = p_num_src-1, so source 0 has top priority after reset.
  - Lock state is cleared.
- Latency: request and data sampled at edge t appear on o_w_bus/o_w_grant after edge t, i.e. 1 cycle.
- Data follows the grant: o_w_bus = i_w_data[winner] captured at the same edge as the grant.
  - While a locked holder keeps the grant, o_w_bus re-samples the holder's data every cycle.
- Arbitration at each edge:
  - LOCKED: if the current holder h has i_w_req[h]=1 and i_w_lock[h]=1, h keeps the grant. Other requests are ignored. l_r_last is unchanged.
  - ARBITRATE: otherwise, search indices l_r_last+1, l_r_last+2, ... modulo p_num_src. The first index with req=1 wins, and l_r_last becomes that index.
  - IDLE: if no request is present, o_w_grant=0, o_w_bus_valid=0, o_w_bus=0 (zero bus keeps downstream OR-tolerant logic safe), and l_r_last is unchanged.
- Holder dropping req releases the bus even if lock is still high. Lock without req has no effect.
- Lock asserted by a non-holder has no effect until that source wins normally.
- A single requester re-wins every cycle with no bubble (back-to-back grants allowed).
- Wrap-around: after source p_num_src-1 wins, the search starts at 0.
- o_w_grant is always one-hot or zero. o_w_src_id always matches o_w_grant.
- Data of non-granted sources is ignored: no OR-merging.

Optional Feature:
- Macro: BUS_CONTENTION_CNT_EN.
- With the macro defined:
  - o_w_contention_cnt increments on each edge where popcount(i_w_req) >= 2, including cycles where a locked holder blocks others.
  - The counter saturates at 16'hFFFF and is cleared only by reset.
- Without the macro: no counter register is built and o_w_contention_cnt is tied to 0.

Test Plan:
- Reset then idle: i_w_reset pulse, req=0 for 5 cycles -> grant=0, valid=0, bus=0, src_id=0 throughout. Assert reset mid-grant -> all outputs 0 immediately, without waiting for a clock edge.
- Single source: req=7'b0000100, data[2]=16'hA5A5 held 3 cycles -> from the next edge, grant=7'b0000100, src_id=2, bus=16'hA5A5, valid=1 for 3 consecutive cycles.
- Round robin: req=7'b1000101 held 4 cycles after reset -> grant sequence src 0, 2, 6, 0. Bus carries data[0], data[2], data[6], data[0] respectively.
- Lock: src 1 wins with lock=1, req=7'b0001010 held 3 cycles -> src 1 granted all 3 cycles. Then drop lock[1] -> next grant goes to src 3.
- Release by req drop: src 1 holds lock=1, then req[1]=0 while req[4]=1 -> next edge grant=src 4 and data[4] is on the bus.
- Contention counter (BUS_CONTENTION_CNT_EN): 10 cycles with req=7'b0000011 -> cnt=10. Preload via 65540 contended cycles -> cnt=16'hFFFF, stays saturated. Without the macro -> cnt=0 throughout.
